// File: rtl/voice_pkg.sv
// Shared definitions for the voice allocator: state encodings, widths,
// event-type codes and the captured event record.
package voice_pkg;

  localparam int NOTE_W     = 7;
  localparam int VOICES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  localparam logic EV_OFF = 1'b0;
  localparam logic EV_ON  = 1'b1;

  typedef struct packed {
    logic              typ;
    logic [NOTE_W-1:0] num;
    logic [NOTE_W-1:0] vel;
  } event_t;

  // Note-on with zero velocity is the running-status idiom for note-off,
  // and a simultaneous on+off strobe is resolved as an off.
  function automatic logic ev_type(input logic on, input logic off,
                                   input logic [NOTE_W-1:0] vel);
    return (on && !off && (vel != '0)) ? EV_ON : EV_OFF;
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Event/voice bus between the MIDI decoder side and the voice pool.
//   NOTE_NUM/NOTE_VEL/NOTE_ON/NOTE_OFF : incoming note event (master drives)
//   VOICE_NUM/VOICE_VEL                : packed per-voice note and velocity
//   VOICE_GATE/VOICE_TRIG              : per-voice key-down and start pulse
//   BUSY/DROP                          : allocator status
interface voice_allocator_if
  import voice_pkg::*;
#(
  parameter int VOICES = VOICES_DEF
);

  logic [NOTE_W-1:0]        NOTE_NUM;
  logic [NOTE_W-1:0]        NOTE_VEL;
  logic                     NOTE_ON;
  logic                     NOTE_OFF;
  logic [NOTE_W*VOICES-1:0] VOICE_NUM;
  logic [NOTE_W*VOICES-1:0] VOICE_VEL;
  logic [VOICES-1:0]        VOICE_GATE;
  logic [VOICES-1:0]        VOICE_TRIG;
  logic                     BUSY;
  logic                     DROP;

  modport master (
    output NOTE_NUM, NOTE_VEL, NOTE_ON, NOTE_OFF,
    input  VOICE_NUM, VOICE_VEL, VOICE_GATE, VOICE_TRIG, BUSY, DROP
  );

  modport slave (
    input  NOTE_NUM, NOTE_VEL, NOTE_ON, NOTE_OFF,
    output VOICE_NUM, VOICE_VEL, VOICE_GATE, VOICE_TRIG, BUSY, DROP
  );

endinterface

// File: rtl/register_clr.sv
// Loadable register with synchronous clear.
//   CLK, RST : clock and synchronous active-high clear
//   EN       : load D into Q
//   D, Q     : data in / registered data out
module register_clr #(
  parameter int W = 7
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q <= '0;
    end else if (EN) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/voice_lru.sv
// Recency ranks for the voice pool. Rank 0 is the most recently
// allocated voice, rank VOICES-1 the oldest.
//   CLK, RST, CE : clock, synchronous reset, clock enable
//   UPD, UPD_IDX : promote voice UPD_IDX to rank 0
//   RANKS        : packed ranks, voice i at [RANK_W*i +: RANK_W]
//   OLDEST_IDX   : voice currently holding rank VOICES-1
module voice_lru #(
  parameter int VOICES = 4,
  parameter int RANK_W = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CE,
  input  logic                     UPD,
  input  logic [RANK_W-1:0]        UPD_IDX,
  output logic [RANK_W*VOICES-1:0] RANKS,
  output logic [RANK_W-1:0]        OLDEST_IDX
);

  logic [RANK_W-1:0] rank_reg [VOICES];
  logic [RANK_W-1:0] upd_rank;

  assign upd_rank = rank_reg[UPD_IDX];

  // Every voice newer than the promoted one ages by one; older voices keep
  // their rank, so the set stays a permutation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < VOICES; i++) begin
        rank_reg[i] <= RANK_W'(i);
      end
    end else if (CE && UPD) begin
      for (int i = 0; i < VOICES; i++) begin
        if (UPD_IDX == RANK_W'(i)) begin
          rank_reg[i] <= '0;
        end else if (rank_reg[i] < upd_rank) begin
          rank_reg[i] <= rank_reg[i] + RANK_W'(1);
        end
      end
    end
  end

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_pack
    assign RANKS[gi*RANK_W +: RANK_W] = rank_reg[gi];
  end

  always_comb begin
    OLDEST_IDX = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (rank_reg[i] == RANK_W'(VOICES - 1)) begin
        OLDEST_IDX = RANK_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Shares a pool of VOICES synth voices between MIDI note events.
// Note-on: retrigger a voice holding the same note, else the lowest free
// voice, else steal the least recently allocated voice. One event is
// examined per VOICES+1 CE cycles; a one-deep pending slot absorbs an
// event arriving meanwhile, further events are dropped.
//   CLK, RST, CE : clock, synchronous active-high reset, clock enable
//   bus          : note event inputs and per-voice outputs (slave side)
module voice_allocator
  import voice_pkg::*;
#(
  parameter int VOICES = VOICES_DEF,
  parameter int RANK_W = $clog2(VOICES)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  voice_allocator_if.slave   bus
);

  state_t            state_reg;
  event_t            evt_reg;
  event_t            pend_reg;
  event_t            in_evt;
  logic              pend_valid_reg;
  logic              in_valid;
  logic [RANK_W-1:0] idx_reg;
  logic              match_found_reg;
  logic [RANK_W-1:0] match_idx_reg;
  logic              free_found_reg;
  logic [RANK_W-1:0] free_idx_reg;
  logic [RANK_W-1:0] oldest_idx_reg;
  logic [VOICES-1:0] gate_reg;
  logic [VOICES-1:0] trig_reg;
  logic              drop_reg;

  logic [NOTE_W-1:0]        num_q [VOICES];
  logic [NOTE_W-1:0]        vel_q [VOICES];
  logic [NOTE_W*VOICES-1:0] num_bus;
  logic [NOTE_W*VOICES-1:0] vel_bus;
  logic [RANK_W*VOICES-1:0] ranks;
  logic [RANK_W-1:0]        rank_arr [VOICES];
  logic [RANK_W-1:0]        lru_oldest;
  logic [RANK_W-1:0]        tgt_idx;
  logic                     apply_on;
  logic                     cur_gate;
  logic [NOTE_W-1:0]        cur_num;

  assign in_valid = bus.NOTE_ON | bus.NOTE_OFF;
  assign in_evt   = {ev_type(bus.NOTE_ON, bus.NOTE_OFF, bus.NOTE_VEL),
                     bus.NOTE_NUM, bus.NOTE_VEL};

  assign cur_gate = gate_reg[idx_reg];
  assign cur_num  = num_q[idx_reg];
  assign apply_on = (state_reg == ST_APPLY) && (evt_reg.typ == EV_ON);

  // Off events only ever act on a matching voice; on events fall through
  // match -> free -> oldest.
  always_comb begin
    tgt_idx = match_idx_reg;
    if (evt_reg.typ == EV_ON && !match_found_reg) begin
      tgt_idx = free_found_reg ? free_idx_reg : oldest_idx_reg;
    end
  end

  voice_lru #(
    .VOICES (VOICES),
    .RANK_W (RANK_W)
  ) u_lru (
    .CLK        (CLK),
    .RST        (RST),
    .CE         (CE),
    .UPD        (apply_on),
    .UPD_IDX    (tgt_idx),
    .RANKS      (ranks),
    .OLDEST_IDX (lru_oldest)
  );

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
    logic load_en;
    assign load_en = CE && apply_on && (tgt_idx == RANK_W'(gi));

    register_clr #(.W(NOTE_W)) u_num (
      .CLK (CLK), .RST (RST), .EN (load_en), .D (evt_reg.num), .Q (num_q[gi])
    );
    register_clr #(.W(NOTE_W)) u_vel (
      .CLK (CLK), .RST (RST), .EN (load_en), .D (evt_reg.vel), .Q (vel_q[gi])
    );

    assign num_bus[gi*NOTE_W +: NOTE_W] = num_q[gi];
    assign vel_bus[gi*NOTE_W +: NOTE_W] = vel_q[gi];
    assign rank_arr[gi]                 = ranks[gi*RANK_W +: RANK_W];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= ST_IDLE;
      evt_reg         <= '0;
      pend_reg        <= '0;
      pend_valid_reg  <= 1'b0;
      idx_reg         <= '0;
      match_found_reg <= 1'b0;
      match_idx_reg   <= '0;
      free_found_reg  <= 1'b0;
      free_idx_reg    <= '0;
      oldest_idx_reg  <= '0;
      gate_reg        <= '0;
      trig_reg        <= '0;
      drop_reg        <= 1'b0;
    end else if (CE) begin
      trig_reg <= '0;
      drop_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          idx_reg         <= '0;
          match_found_reg <= 1'b0;
          free_found_reg  <= 1'b0;
          // Seed only; the scan overwrites it at the voice holding the
          // oldest rank.
          oldest_idx_reg  <= lru_oldest;
          if (in_valid) begin
            evt_reg   <= in_evt;
            state_reg <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (!match_found_reg && cur_gate && (cur_num == evt_reg.num)) begin
            match_found_reg <= 1'b1;
            match_idx_reg   <= idx_reg;
          end
          if (!free_found_reg && !cur_gate) begin
            free_found_reg <= 1'b1;
            free_idx_reg   <= idx_reg;
          end
          if (rank_arr[idx_reg] == RANK_W'(VOICES - 1)) begin
            oldest_idx_reg <= idx_reg;
          end
          if (in_valid) begin
            if (pend_valid_reg) begin
              drop_reg <= 1'b1;
            end else begin
              pend_reg       <= in_evt;
              pend_valid_reg <= 1'b1;
            end
          end
          if (idx_reg == RANK_W'(VOICES - 1)) begin
            state_reg <= ST_APPLY;
          end else begin
            idx_reg <= idx_reg + RANK_W'(1);
          end
        end

        ST_APPLY: begin
          if (evt_reg.typ == EV_ON) begin
            gate_reg[tgt_idx] <= 1'b1;
            trig_reg[tgt_idx] <= 1'b1;
          end else if (match_found_reg) begin
            gate_reg[match_idx_reg] <= 1'b0;
          end
          idx_reg         <= '0;
          match_found_reg <= 1'b0;
          free_found_reg  <= 1'b0;
          if (pend_valid_reg) begin
            // The slot is still full on this edge, so a new arrival loses.
            evt_reg        <= pend_reg;
            pend_valid_reg <= 1'b0;
            state_reg      <= ST_SCAN;
            if (in_valid) begin
              drop_reg <= 1'b1;
            end
          end else if (in_valid) begin
            evt_reg   <= in_evt;
            state_reg <= ST_SCAN;
          end else begin
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.VOICE_NUM  = num_bus;
  assign bus.VOICE_VEL  = vel_bus;
  assign bus.VOICE_GATE = gate_reg;
  assign bus.VOICE_TRIG = trig_reg;
  assign bus.BUSY       = (state_reg != ST_IDLE);
  assign bus.DROP       = drop_reg;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with VOICES=4.
module tb_voice_allocator;

  logic CLK = 1'b0;
  logic RST;
  logic CE;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK = ~CLK;

  voice_allocator_if #(.VOICES(4)) bus ();

  voice_allocator #(.VOICES(4), .RANK_W(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .CE  (CE),
    .bus (bus)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] vnum(input int i);
    return 32'(bus.VOICE_NUM[i*7 +: 7]);
  endfunction

  function automatic logic [31:0] vvel(input int i);
    return 32'(bus.VOICE_VEL[i*7 +: 7]);
  endfunction

  // Present one strobe for a single CE edge.
  task automatic send(input logic on, input logic off, input int num, input int vel);
    bus.NOTE_ON  = on;
    bus.NOTE_OFF = off;
    bus.NOTE_NUM = 7'(num);
    bus.NOTE_VEL = 7'(vel);
    $display("event on=%0d off=%0d num=%0d vel=%0d", on, off, num, vel);
    tick();
    bus.NOTE_ON  = 1'b0;
    bus.NOTE_OFF = 1'b0;
  endtask

  // Send and advance to just after the APPLY edge (5 edges later).
  task automatic run_evt(input logic on, input logic off, input int num, input int vel);
    send(on, off, num, vel);
    repeat (5) tick();
  endtask

  initial begin
    RST = 1'b1;
    CE  = 1'b1;
    bus.NOTE_ON  = 1'b0;
    bus.NOTE_OFF = 1'b0;
    bus.NOTE_NUM = '0;
    bus.NOTE_VEL = '0;
    tick();
    tick();
    RST = 1'b0;

    // Reset state
    chk("rst_gate", 32'(bus.VOICE_GATE), 0);
    chk("rst_trig", 32'(bus.VOICE_TRIG), 0);
    chk("rst_num",  32'(bus.VOICE_NUM), 0);
    chk("rst_vel",  32'(bus.VOICE_VEL), 0);
    chk("rst_busy", 32'(bus.BUSY), 0);
    chk("rst_drop", 32'(bus.DROP), 0);

    // First note-on lands on voice 0 after 5 edges
    send(1, 0, 60, 100);
    chk("on1_busy_scan", 32'(bus.BUSY), 1);
    repeat (4) tick();
    chk("on1_gate_early", 32'(bus.VOICE_GATE), 0);
    tick();
    chk("on1_gate", 32'(bus.VOICE_GATE), 4'b0001);
    chk("on1_num0", vnum(0), 60);
    chk("on1_vel0", vvel(0), 100);
    chk("on1_trig", 32'(bus.VOICE_TRIG), 4'b0001);
    chk("on1_busy", 32'(bus.BUSY), 0);
    tick();
    chk("on1_trig_end", 32'(bus.VOICE_TRIG), 0);

    // Retrigger same note
    run_evt(1, 0, 60, 40);
    chk("retrig_vel0", vvel(0), 40);
    chk("retrig_trig", 32'(bus.VOICE_TRIG), 4'b0001);
    chk("retrig_gate", 32'(bus.VOICE_GATE), 4'b0001);
    chk("retrig_num1", vnum(1), 0);
    tick();

    // Note-off keeps num/vel for release
    run_evt(0, 1, 60, 0);
    chk("off_gate", 32'(bus.VOICE_GATE), 0);
    chk("off_num0", vnum(0), 60);
    chk("off_vel0", vvel(0), 40);
    chk("off_trig", 32'(bus.VOICE_TRIG), 0);
    tick();

    // Off for an absent note: nothing changes, no drop
    run_evt(0, 1, 61, 0);
    chk("offx_gate", 32'(bus.VOICE_GATE), 0);
    chk("offx_num", 32'(bus.VOICE_NUM), 60);
    chk("offx_drop", 32'(bus.DROP), 0);
    tick();

    // Velocity-0 note-on acts as note-off (alone and with NOTE_OFF)
    run_evt(1, 0, 60, 100);
    chk("v0a_on_gate", 32'(bus.VOICE_GATE), 4'b0001);
    tick();
    run_evt(1, 0, 60, 0);
    chk("v0a_gate", 32'(bus.VOICE_GATE), 0);
    chk("v0a_trig", 32'(bus.VOICE_TRIG), 0);
    chk("v0a_vel0", vvel(0), 100);
    tick();
    run_evt(1, 0, 60, 90);
    tick();
    run_evt(1, 1, 60, 0);
    chk("v0b_gate", 32'(bus.VOICE_GATE), 0);
    chk("v0b_vel0", vvel(0), 90);
    tick();

    // Fill all voices, then steal oldest
    run_evt(1, 0, 60, 10); tick();
    run_evt(1, 0, 62, 11); tick();
    run_evt(1, 0, 64, 12); tick();
    run_evt(1, 0, 67, 13);
    chk("fill_gate", 32'(bus.VOICE_GATE), 4'b1111);
    chk("fill_num3", vnum(3), 67);
    chk("fill_trig", 32'(bus.VOICE_TRIG), 4'b1000);
    tick();
    run_evt(1, 0, 72, 50);
    chk("steal0_num0", vnum(0), 72);
    chk("steal0_vel0", vvel(0), 50);
    chk("steal0_gate", 32'(bus.VOICE_GATE), 4'b1111);
    chk("steal0_trig", 32'(bus.VOICE_TRIG), 4'b0001);
    tick();
    run_evt(1, 0, 74, 51);
    chk("steal1_num1", vnum(1), 74);
    chk("steal1_trig", 32'(bus.VOICE_TRIG), 4'b0010);
    chk("steal1_num0", vnum(0), 72);
    tick();

    // Back-to-back strobes: pending then drop
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst2_gate", 32'(bus.VOICE_GATE), 0);
    send(1, 0, 60, 100);
    send(1, 0, 62, 101);
    send(1, 0, 64, 102);
    chk("pend_drop", 32'(bus.DROP), 1);
    tick();
    chk("pend_drop_end", 32'(bus.DROP), 0);
    repeat (2) tick();
    chk("pend_first_gate", 32'(bus.VOICE_GATE), 4'b0001);
    chk("pend_first_trig", 32'(bus.VOICE_TRIG), 4'b0001);
    chk("pend_busy", 32'(bus.BUSY), 1);
    repeat (5) tick();
    chk("pend_final_gate", 32'(bus.VOICE_GATE), 4'b0011);
    chk("pend_final_trig", 32'(bus.VOICE_TRIG), 4'b0010);
    chk("pend_num1", vnum(1), 62);
    chk("pend_num2", vnum(2), 0);
    chk("pend_idle", 32'(bus.BUSY), 0);
    tick();

    // Reset mid-scan loses both in-flight and pending events
    send(1, 0, 65, 70);
    send(1, 0, 66, 71);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rstscan_gate", 32'(bus.VOICE_GATE), 0);
    chk("rstscan_num", 32'(bus.VOICE_NUM), 0);
    chk("rstscan_busy", 32'(bus.BUSY), 0);
    repeat (12) tick();
    chk("rstscan_after_gate", 32'(bus.VOICE_GATE), 0);
    chk("rstscan_after_busy", 32'(bus.BUSY), 0);

    // CE low ignores events
    CE = 1'b0;
    send(1, 0, 60, 100);
    repeat (6) tick();
    chk("ce_busy", 32'(bus.BUSY), 0);
    chk("ce_gate", 32'(bus.VOICE_GATE), 0);
    CE = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Scheduler that shares a fixed pool of synth voices between incoming MIDI note events. It sits between the midi decoder (NOTE_ON_OUT/NOTE_OFF_OUT, NOTE_NUM, NOTE_VEL) and the oscillator/envelope voices.
- Allocation order for a NOTE_ON:
  1. Retrigger a voice already holding the same note.
  2. Otherwise take the lowest-index free voice.
  3. Otherwise steal the least-recently-allocated voice.
- A one-deep pending buffer absorbs back-to-back events.

Parameters:
- VOICES, 4, number of voices (2..8); sets scan length and output widths.
- RANK_W, 2, rank width = clog2(VOICES).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- CE  in  1  clock enable; all state holds and event inputs are ignored when low.
- NOTE_NUM  in  7  note number of the event.
- NOTE_VEL  in  7  velocity of the event.
- NOTE_ON  in  1  one-CE-cycle note-on strobe.
- NOTE_OFF  in  1  one-CE-cycle note-off strobe.
- VOICE_NUM  out  7*VOICES  packed note per voice; voice i occupies bits [7i+6:7i].
- VOICE_VEL  out  7*VOICES  packed velocity per voice.
- VOICE_GATE  out  VOICES  voice i holds an active (key-down) note.
- VOICE_TRIG  out  VOICES  one-CE-cycle pulse when voice i is (re)started.
- BUSY  out  1  high in any state other than IDLE.
- DROP  out  1  one-CE-cycle pulse when an event is discarded.

Behaviour:
- Reset (synchronous, RST=1 at a CLK edge, regardless of CE):
  - All outputs are 0; state is IDLE; the pending buffer is empty.
  - rank[i]=i. Rank 0 is newest, rank VOICES-1 is oldest.
  - Reset mid-scan abandons the event and clears the pending buffer.
- Event classification:
  - OFF if NOTE_OFF=1, or if NOTE_ON=1 with NOTE_VEL=0. NOTE_ON and NOTE_OFF both high counts as OFF.
  - ON if NOTE_ON=1 and NOTE_VEL!=0.
  - The event register captures {type, NOTE_NUM, NOTE_VEL}.
- FSM states are IDLE, SCAN, APPLY. All transitions occur only on CE=1 edges.
  - IDLE: an event at edge E0 is captured and the FSM goes to SCAN with idx=0.
  - SCAN: one voice is examined per edge, idx = 0..VOICES-1. Each edge records:
    - match: lowest idx with gate=1 and num==event.num;
    - free: lowest idx with gate=0;
    - oldest: idx with rank==VOICES-1.
    - After idx=VOICES-1 the FSM goes to APPLY.
  - APPLY (edge E(VOICES+1)) updates the outputs:
    - ON with match m: VOICE_VEL[m]=vel; TRIG[m] pulses; rank update on m.
    - ON with no match and free f: NUM[f]=num, VEL[f]=vel, GATE[f]=1; TRIG[f] pulses; rank update on f.
    - ON with all voices gated: NUM/VEL of the oldest voice are overwritten, its GATE stays 1, its TRIG pulses; rank update on it.
    - OFF with match m: GATE[m]=0. NUM[m] and VEL[m] are kept for envelope release. Ranks are unchanged.
    - OFF with no match: no output change, no DROP.
    - Next state is SCAN if the pending buffer is full (buffer is consumed), otherwise IDLE.
- Rank update on voice v (old rank r): every u with rank[u]<r increments; rank[v]=0. Ranks always remain a permutation of 0..VOICES-1.
- Latency:
  - Outputs reflect an event after VOICES+1 CE edges following the sampling edge; this is 5 for VOICES=4.
  - VOICE_TRIG is high for exactly the CE cycle following APPLY.
  - Event throughput is one per VOICES+1 CE cycles.
- Pending buffer:
  - An event arriving while BUSY is stored if the buffer is empty.
  - If the buffer is full, the event is discarded and DROP pulses for one CE cycle.
  - The pending event's classification is fixed at capture.
- Invariant: at most one gated voice per note number.

Decomposition:
- Shared package voice_pkg holds:
  - state encodings ST_IDLE, ST_SCAN, ST_APPLY;
  - NOTE_W=7;
  - default VOICES=4;
  - event-type constants EV_ON and EV_OFF.
- One sub-module, voice_lru, holds the rank registers. Its inputs are CLK, RST, CE, UPD, UPD_IDX. Its outputs are the packed ranks and OLDEST_IDX. It is combinationally decoded.
- Existing register_clr is reused for the per-voice NUM and VEL storage.

Test Plan:
- Reset, then ON(60, vel 100) → after 5 CE edges: GATE=0001, VOICE_NUM[0]=60, VEL[0]=100, TRIG=0001 for one cycle, BUSY low afterward.
- ON 60, 62, 64, 67 in sequence, then ON 72 → 72 steals voice 0 (oldest): NUM[0]=72, GATE=1111, TRIG=0001. A subsequent ON 74 steals voice 1.
- ON 60 then OFF 60 → GATE[0]=0, NUM[0]=60 and VEL[0] retained. OFF 61 (absent) → no output change, no DROP.
- ON 60 vel 100, then ON 60 vel 40 → same voice retriggered: VEL[0]=40, TRIG=0001, GATE=0001, no second voice used.
- Three strobes on consecutive CE cycles (ON 60, ON 62, ON 64) → first processed, second pending then processed, third causes a DROP pulse. Final state: GATE=0011.
- NOTE_ON with vel 0 and note 60 (together with NOTE_OFF) → treated as OFF. RST asserted during SCAN → all outputs 0 the next cycle, and the pending event is lost.
